// File: rtl/pq_array_ctrl.sv
// pq_array_ctrl: command front end for the priority-queue cell array; tracks occupancy and sequences push/pop/drop.
// Optional WAIT-state completion timeout enabled by defining PQ_CTRL_TIMEOUT_EN.
module pq_array_ctrl #(
  parameter int DEPTH     = 8,
  parameter int TW        = 4,
  parameter int PW        = 4,
  parameter int TO_CYCLES = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [1:0]                   req_op_i,
  input  logic [TW-1:0]                req_id_i,
  input  logic [PW-1:0]                req_prio_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic                         rsp_err_o,
  output logic [TW-1:0]                rsp_id_o,
  output logic [PW-1:0]                rsp_prio_o,
  output logic                         push_o,
  output logic                         pop_o,
  output logic                         drop_o,
  output logic [TW-1:0]                data_id_o,
  output logic [PW-1:0]                data_prio_o,
  input  logic                         push_vld_i,
  input  logic                         pop_vld_i,
  input  logic                         drop_vld_i,
  input  logic                         drop_hit_i,
  input  logic [TW-1:0]                head_id_i,
  input  logic [PW-1:0]                head_prio_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [1:0] OP_PUSH = 2'd0, OP_POP = 2'd1, OP_DROP = 2'd2;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic [1:0] op;
  logic reject, done, to_hit;
  assign full_o  = count_o == CW'(DEPTH);
  assign empty_o = count_o == '0;
  assign reject  = (req_op_i == OP_PUSH && (full_o || req_id_i == '0)) ||
                   (req_op_i == OP_POP && empty_o) || req_op_i == 2'd3;
  assign done    = (op == OP_PUSH && push_vld_i) || (op == OP_POP && pop_vld_i) ||
                   (op == OP_DROP && drop_vld_i);
`ifdef PQ_CTRL_TIMEOUT_EN
  localparam int TOW = $clog2(TO_CYCLES+1);
  logic [TOW-1:0] to_cnt;
  assign to_hit = to_cnt == TOW'(TO_CYCLES-1);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) to_cnt <= '0;
    else to_cnt <= state == WAIT ? to_cnt + 1'b1 : '0;
`else
  // Never true for a legal TO_CYCLES: WAIT only leaves on a matching completion.
  assign to_hit = TO_CYCLES < 0;
`endif
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state       <= IDLE;
      op          <= '0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_id_o    <= '0;
      rsp_prio_o  <= '0;
      push_o      <= 1'b0;
      pop_o       <= 1'b0;
      drop_o      <= 1'b0;
      data_id_o   <= '0;
      data_prio_o <= '0;
      count_o     <= '0;
    end else begin
      push_o <= 1'b0;
      pop_o  <= 1'b0;
      drop_o <= 1'b0;
      case (state)
        IDLE: if (req_valid_i) begin
          op          <= req_op_i;
          req_ready_o <= 1'b0;
          if (reject) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            rsp_id_o    <= req_id_i;
          end else begin
            state       <= ISSUE;
            data_id_o   <= req_id_i;
            data_prio_o <= req_prio_i;
            push_o      <= req_op_i == OP_PUSH;
            pop_o       <= req_op_i == OP_POP;
            drop_o      <= req_op_i == OP_DROP;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: if (done) begin
          state       <= RESP;
          rsp_valid_o <= 1'b1;
          rsp_id_o    <= op == OP_POP ? head_id_i : data_id_o;
          rsp_prio_o  <= op == OP_POP ? head_prio_i : '0;
          rsp_err_o   <= op == OP_DROP && !drop_hit_i;
          if (op == OP_PUSH && !full_o) count_o <= count_o + 1'b1;
          else if ((op == OP_POP || (op == OP_DROP && drop_hit_i)) && !empty_o) count_o <= count_o - 1'b1;
        end else if (to_hit) begin
          state       <= RESP;
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= 1'b1;
          rsp_id_o    <= data_id_o;
        end
        RESP: if (rsp_ready_i) begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
          rsp_valid_o <= 1'b0;
          rsp_err_o   <= 1'b0;
          rsp_id_o    <= '0;
          rsp_prio_o  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
